// File: rtl/hls_slave_port_driver_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : hls_slave_port_driver_if
// Brief    : Host command/response stream plus main slave-port and start/done
//            signals for the hls_slave_port_driver.
// Revision : 1.0 - initial release
// ============================================================================
interface hls_slave_port_driver_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8,
    parameter int SIZE_W = 4
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [ADDR_W-1:0]     cmd_addr;
    logic [DATA_W-1:0]     cmd_wdata;
    logic [SIZE_W-1:0]     cmd_size;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [1:0]            rsp_status;
    logic [DATA_W-1:0]     rsp_data;
    logic [31:0]           rsp_cycles;

    logic [1:0]            S_oe_ram;
    logic [1:0]            S_we_ram;
    logic [2*ADDR_W-1:0]   S_addr_ram;
    logic [2*DATA_W-1:0]   S_Wdata_ram;
    logic [2*SIZE_W-1:0]   S_data_ram_size;
    logic [2*DATA_W-1:0]   Sout_Rdata_ram;
    logic [1:0]            Sout_DataRdy;
    logic                  start_port;
    logic                  done_port;

    // Driver side: consumes host commands, drives the accelerator ports
    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_size, rsp_ready,
               Sout_Rdata_ram, Sout_DataRdy, done_port,
        output cmd_ready, rsp_valid, rsp_status, rsp_data, rsp_cycles,
               S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size,
               start_port
    );

    // Host/accelerator side
    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_size, rsp_ready,
               Sout_Rdata_ram, Sout_DataRdy, done_port,
        input  cmd_ready, rsp_valid, rsp_status, rsp_data, rsp_cycles,
               S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size,
               start_port
    );
endinterface
`default_nettype wire

// File: rtl/hls_slave_port_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : hls_slave_port_driver
// Brief    : Turns one-at-a-time host commands into channel-0 slave-port bus
//            cycles or a start pulse to main, and returns one response each.
// Revision : 1.0 - initial release
// ============================================================================
module hls_slave_port_driver #(
    parameter int          ADDR_W      = 7,
    parameter int          DATA_W      = 8,
    parameter int          SIZE_W      = 4,
    parameter int          MEM_TIMEOUT = 16,
    parameter int unsigned RUN_LIMIT   = 200000000
) (
    input  wire logic clock,
    input  wire logic reset,
    hls_slave_port_driver_if.slave bus
);

    localparam int                  c_WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_ONE = c_WAIT_W'(1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(MEM_TIMEOUT);
    localparam logic [31:0]         c_RUN_MAX  = 32'(RUN_LIMIT);

    localparam logic [1:0] c_ST_OK      = 2'b00;
    localparam logic [1:0] c_ST_MEM_TO  = 2'b01;
    localparam logic [1:0] c_ST_RUN_TO  = 2'b10;
    localparam logic [1:0] c_ST_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR    = 3'd1,
        S_RD    = 3'd2,
        S_START = 3'd3,
        S_RUN   = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    state_t                r_state,  w_state_nxt;
    logic [ADDR_W-1:0]     r_addr,   w_addr_nxt;
    logic [DATA_W-1:0]     r_wdata,  w_wdata_nxt;
    logic [SIZE_W-1:0]     r_size,   w_size_nxt;
    logic [c_WAIT_W-1:0]   r_wait,   w_wait_nxt;
    logic [31:0]           r_cnt,    w_cnt_nxt;
    logic [1:0]            r_status, w_status_nxt;
    logic [DATA_W-1:0]     r_data,   w_data_nxt;
    logic [31:0]           r_cycles, w_cycles_nxt;
    logic                  w_req;

    // Channel 1 of main's slave port is never used
    logic w_unused_ch1;
    assign w_unused_ch1 = ^{bus.Sout_Rdata_ram[2*DATA_W-1:DATA_W], bus.Sout_DataRdy[1]};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_size   <= '0;
            r_wait   <= '0;
            r_cnt    <= '0;
            r_status <= '0;
            r_data   <= '0;
            r_cycles <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_addr   <= w_addr_nxt;
            r_wdata  <= w_wdata_nxt;
            r_size   <= w_size_nxt;
            r_wait   <= w_wait_nxt;
            r_cnt    <= w_cnt_nxt;
            r_status <= w_status_nxt;
            r_data   <= w_data_nxt;
            r_cycles <= w_cycles_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_addr;
        w_wdata_nxt  = r_wdata;
        w_size_nxt   = r_size;
        w_wait_nxt   = r_wait;
        w_cnt_nxt    = r_cnt;
        w_status_nxt = r_status;
        w_data_nxt   = r_data;
        w_cycles_nxt = r_cycles;

        case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    w_addr_nxt   = bus.cmd_addr;
                    w_wdata_nxt  = bus.cmd_wdata;
                    w_size_nxt   = bus.cmd_size;
                    w_wait_nxt   = c_WAIT_ONE;
                    w_cnt_nxt    = 32'd1;
                    w_status_nxt = c_ST_OK;
                    w_data_nxt   = '0;
                    w_cycles_nxt = '0;
                    case (bus.cmd_op)
                        2'd0:    w_state_nxt = S_WR;
                        2'd1:    w_state_nxt = S_RD;
                        2'd2:    w_state_nxt = S_START;
                        default: begin
                            w_status_nxt = c_ST_ILLEGAL;
                            w_state_nxt  = S_RESP;
                        end
                    endcase
                end
            end
            S_WR, S_RD: begin
                // DataRdy wins over a timeout landing in the same cycle
                if (bus.Sout_DataRdy[0]) begin
                    if (r_state == S_RD) begin
                        w_data_nxt = bus.Sout_Rdata_ram[DATA_W-1:0];
                    end
                    w_state_nxt = S_RESP;
                end else if (r_wait >= c_WAIT_MAX) begin
                    w_status_nxt = c_ST_MEM_TO;
                    w_data_nxt   = '0;
                    w_state_nxt  = S_RESP;
                end else begin
                    w_wait_nxt = r_wait + c_WAIT_ONE;
                end
            end
            S_START: begin
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (bus.done_port) begin
                    w_cycles_nxt = r_cnt;
                    w_state_nxt  = S_RESP;
                end else if (r_cnt >= c_RUN_MAX) begin
                    w_cycles_nxt = c_RUN_MAX;
                    w_status_nxt = c_ST_RUN_TO;
                    w_state_nxt  = S_RESP;
                end else if (r_cnt != '1) begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_req = (r_state == S_WR) || (r_state == S_RD);

    // Ready is masked while reset is held so nothing looks acceptable then
    assign bus.cmd_ready       = (r_state == S_IDLE) && !reset;
    assign bus.rsp_valid       = (r_state == S_RESP);
    assign bus.rsp_status      = r_status;
    assign bus.rsp_data        = r_data;
    assign bus.rsp_cycles      = r_cycles;
    assign bus.start_port      = (r_state == S_START);
    assign bus.S_we_ram        = {1'b0, r_state == S_WR};
    assign bus.S_oe_ram        = {1'b0, r_state == S_RD};
    assign bus.S_addr_ram      = {{ADDR_W{1'b0}}, w_req ? r_addr  : {ADDR_W{1'b0}}};
    assign bus.S_Wdata_ram     = {{DATA_W{1'b0}}, w_req ? r_wdata : {DATA_W{1'b0}}};
    assign bus.S_data_ram_size = {{SIZE_W{1'b0}}, w_req ? r_size  : {SIZE_W{1'b0}}};

endmodule
`default_nettype wire

// File: tb/tb_hls_slave_port_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_hls_slave_port_driver
// Brief    : Randomized self-checking bench with a transaction-level timing
//            model of the driver and a per-cycle output comparator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hls_slave_port_driver;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;
    localparam int SIZE_W = 4;
    localparam int MT     = 16;
    localparam int RL     = 50;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    hls_slave_port_driver_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W)) bus ();

    hls_slave_port_driver #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W),
        .MEM_TIMEOUT(MT), .RUN_LIMIT(RL)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Expected outputs for the current cycle, maintained by the model
    logic              e_ready, e_rvalid, e_start, e_oe, e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata, e_data;
    logic [SIZE_W-1:0] e_size;
    logic [1:0]        e_status;
    logic [31:0]       e_cycles;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        chk("cmd_ready",  32'(bus.cmd_ready),  32'(e_ready));
        chk("rsp_valid",  32'(bus.rsp_valid),  32'(e_rvalid));
        chk("start_port", 32'(bus.start_port), 32'(e_start));
        chk("S_oe_ram",   32'(bus.S_oe_ram),   32'({1'b0, e_oe}));
        chk("S_we_ram",   32'(bus.S_we_ram),   32'({1'b0, e_we}));
        chk("addr_ch1",   32'(bus.S_addr_ram[2*ADDR_W-1:ADDR_W]),      32'd0);
        chk("wdata_ch1",  32'(bus.S_Wdata_ram[2*DATA_W-1:DATA_W]),     32'd0);
        chk("size_ch1",   32'(bus.S_data_ram_size[2*SIZE_W-1:SIZE_W]), 32'd0);
        if (e_oe || e_we) begin
            chk("addr_ch0", 32'(bus.S_addr_ram[ADDR_W-1:0]),      32'(e_addr));
            chk("size_ch0", 32'(bus.S_data_ram_size[SIZE_W-1:0]), 32'(e_size));
        end
        if (e_we) chk("wdata_ch0", 32'(bus.S_Wdata_ram[DATA_W-1:0]), 32'(e_wdata));
        if (e_rvalid) begin
            chk("rsp_status", 32'(bus.rsp_status), 32'(e_status));
            chk("rsp_data",   32'(bus.rsp_data),   32'(e_data));
            chk("rsp_cycles", bus.rsp_cycles,      e_cycles);
        end
    end

    task automatic exp_busy();
        e_ready = 0; e_rvalid = 0; e_start = 0; e_oe = 0; e_we = 0;
    endtask

    task automatic exp_idle();
        exp_busy();
        e_ready = 1;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Inputs that the driver must ignore in the current state are scrambled
    task automatic junk();
        bus.cmd_valid      = 1'($urandom);
        bus.cmd_op         = 2'($urandom);
        bus.cmd_addr       = ADDR_W'($urandom);
        bus.cmd_wdata      = DATA_W'($urandom);
        bus.cmd_size       = SIZE_W'($urandom);
        bus.rsp_ready      = 1'($urandom);
        bus.Sout_Rdata_ram = (2*DATA_W)'($urandom);
        bus.Sout_DataRdy   = 2'($urandom);
        bus.done_port      = 1'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            junk();
            bus.cmd_valid = 1'b0;
            exp_idle();
            step();
        end
        junk();
        bus.cmd_valid = 1'b0;
        exp_idle();
    endtask

    // lat: request cycle in which DataRdy[0] rises (0 = never)
    // k:   RUN cycle in which done rises (0 = never)
    task automatic do_cmd(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, input logic [SIZE_W-1:0] size,
                          input int lat, input logic [DATA_W-1:0] rdata, input int k,
                          input int rdly,
                          output logic [1:0] o_st, output logic [DATA_W-1:0] o_data,
                          output logic [31:0] o_cyc);
        logic        mem_ok, run_ok;
        int          len;
        logic [1:0]  m_st;
        logic [DATA_W-1:0] m_data;
        logic [31:0] m_cyc;
        junk();
        bus.cmd_valid = 1'b1;
        bus.cmd_op = op; bus.cmd_addr = addr; bus.cmd_wdata = wdata; bus.cmd_size = size;
        exp_idle();
        step();
        m_st = 2'd0; m_data = '0; m_cyc = 32'd0;
        if (op == 2'd0 || op == 2'd1) begin
            mem_ok = (lat >= 1) && (lat <= MT);
            len    = mem_ok ? lat : MT;
            for (int i = 1; i <= len; i++) begin
                junk();
                bus.Sout_DataRdy[0] = (i == lat);
                if (i == lat) bus.Sout_Rdata_ram[DATA_W-1:0] = rdata;
                exp_busy();
                e_we = (op == 2'd0); e_oe = (op == 2'd1);
                e_addr = addr; e_wdata = wdata; e_size = size;
                step();
            end
            m_st   = mem_ok ? 2'd0 : 2'd1;
            m_data = (mem_ok && op == 2'd1) ? rdata : '0;
        end else if (op == 2'd2) begin
            junk();
            exp_busy();
            e_start = 1;
            step();
            run_ok = (k >= 1) && (k <= RL);
            len    = run_ok ? k : RL;
            for (int j = 1; j <= len; j++) begin
                junk();
                bus.done_port = (j == k);
                exp_busy();
                step();
            end
            m_st  = run_ok ? 2'd0 : 2'd2;
            m_cyc = 32'(len);
        end else begin
            m_st = 2'd3;
        end
        for (int r = 0; r <= rdly; r++) begin
            junk();
            bus.rsp_ready = (r == rdly);
            exp_busy();
            e_rvalid = 1; e_status = m_st; e_data = m_data; e_cycles = m_cyc;
            if (r == rdly) begin
                @(negedge clock);
                o_st = bus.rsp_status; o_data = bus.rsp_data; o_cyc = bus.rsp_cycles;
            end
            step();
        end
        junk();
        bus.cmd_valid = 1'b0;
        exp_idle();
    endtask

    logic [1:0]        st;
    logic [DATA_W-1:0] dat;
    logic [31:0]       cyc;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        junk();
        reset = 1'b1;
        exp_busy();
        for (int i = 0; i < 3; i++) step();
        reset = 1'b0;
        idle(1);

        // Directed cases with hand-computed expectations
        do_cmd(2'd0, 7'h05, 8'hA5, 4'd8, 2, 8'h00, 0, 0, st, dat, cyc);
        chk("wr_status", 32'(st), 32'd0);
        do_cmd(2'd1, 7'h05, 8'h00, 4'd8, 2, 8'hA5, 0, 0, st, dat, cyc);
        chk("rd_status", 32'(st), 32'd0);
        chk("rd_data",   32'(dat), 32'hA5);
        do_cmd(2'd2, 7'h00, 8'h00, 4'd0, 0, 8'h00, 10, 0, st, dat, cyc);
        chk("run_status", 32'(st), 32'd0);
        chk("run_cycles", cyc, 32'd10);
        do_cmd(2'd1, 7'h11, 8'h00, 4'd8, 0, 8'h00, 0, 1, st, dat, cyc);
        chk("memto_status", 32'(st), 32'd1);
        chk("memto_data",   32'(dat), 32'd0);
        do_cmd(2'd0, 7'h12, 8'h3C, 4'd8, 16, 8'h00, 0, 0, st, dat, cyc);
        chk("edge_to_status", 32'(st), 32'd0);
        do_cmd(2'd2, 7'h00, 8'h00, 4'd0, 0, 8'h00, 0, 0, st, dat, cyc);
        chk("runto_status", 32'(st), 32'd2);
        chk("runto_cycles", cyc, 32'd50);
        do_cmd(2'd3, 7'h33, 8'h77, 4'd2, 0, 8'h00, 0, 5, st, dat, cyc);
        chk("illegal_status", 32'(st), 32'd3);

        // Reset in the third RUN cycle aborts the command
        junk();
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'd2;
        exp_idle();
        step();
        junk(); exp_busy(); e_start = 1; step();
        for (int j = 1; j <= 3; j++) begin
            junk();
            bus.done_port = 1'b0;
            if (j == 3) reset = 1'b1;
            exp_busy();
            step();
        end
        reset = 1'b0;
        idle(2);
        do_cmd(2'd0, 7'h21, 8'h5A, 4'd8, 3, 8'h00, 0, 0, st, dat, cyc);
        chk("post_reset_wr", 32'(st), 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 60; n++) begin
            logic [1:0] op;
            op = 2'($urandom);
            do_cmd(op, ADDR_W'($urandom), DATA_W'($urandom), SIZE_W'($urandom),
                   $urandom_range(0, MT + 2), DATA_W'($urandom), $urandom_range(0, RL + 5),
                   $urandom_range(0, 3), st, dat, cyc);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
